// File: rtl/ps2_key_matrix_if.sv
// PS/2 keyboard front-end bundle: raw PS/2 lines in, 8x8 key matrix and byte strobe out.
interface ps2_key_matrix_if;
  logic            ps2_clk;
  logic            ps2_data;
  logic [7:0][7:0] km;
  logic            resetkey;
  logic            code_valid;
  logic [7:0]      code;

  modport master (
    output ps2_clk, ps2_data,
    input  km, resetkey, code_valid, code
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output km, resetkey, code_valid, code
  );
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 receiver and decoder maintaining the LM80C 8x8 active-low key matrix
// plus the F11 hard-reset key.
module ps2_key_matrix #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 29491
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_matrix_if.slave  bus
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

  logic [1:0]            clk_sync_q, data_sync_q;
  logic [FILTER_LEN-1:0] clk_hist_q;
  logic                  clk_filt_q, fall, rx_data;
  logic [3:0]            bit_cnt_q;
  logic [8:0]            sr_q;
  logic [TW-1:0]         tmo_q;
  logic                  code_valid_q;
  logic [7:0]            code_q;
  state_e                st_q;
  logic [2:0]            skip_q;
  logic [7:0][7:0]       km_q;
  logic                  resetkey_q;
  logic                  ext;
  logic [6:0]            lk;

  // {ext,code} -> {hit,row,col}; octal literal 7'o1RC reads directly as row R, col C.
  function automatic logic [6:0] lookup(input logic [8:0] key);
    logic [6:0] l;
    l = '0;
    case (key)
      9'h066: l = 7'o100;  9'h05A: l = 7'o101;  9'h174: l = 7'o102;  9'h083: l = 7'o103;
      9'h005: l = 7'o104;  9'h004: l = 7'o105;  9'h003: l = 7'o106;  9'h172: l = 7'o107;
      9'h026: l = 7'o110;  9'h01D: l = 7'o111;  9'h01C: l = 7'o112;  9'h025: l = 7'o113;
      9'h01A: l = 7'o114;  9'h01B: l = 7'o115;  9'h024: l = 7'o116;  9'h012: l = 7'o117;
      9'h02E: l = 7'o120;  9'h02D: l = 7'o121;  9'h023: l = 7'o122;  9'h036: l = 7'o123;
      9'h021: l = 7'o124;  9'h02B: l = 7'o125;  9'h02C: l = 7'o126;  9'h022: l = 7'o127;
      9'h03D: l = 7'o130;  9'h035: l = 7'o131;  9'h034: l = 7'o132;  9'h03E: l = 7'o133;
      9'h032: l = 7'o134;  9'h033: l = 7'o135;  9'h03C: l = 7'o136;  9'h02A: l = 7'o137;
      9'h046: l = 7'o140;  9'h043: l = 7'o141;  9'h03B: l = 7'o142;  9'h045: l = 7'o143;
      9'h03A: l = 7'o144;  9'h042: l = 7'o145;  9'h044: l = 7'o146;  9'h031: l = 7'o147;
      9'h055: l = 7'o150;  9'h04D: l = 7'o151;  9'h04B: l = 7'o152;  9'h04E: l = 7'o153;
      9'h049: l = 7'o154;  9'h04C: l = 7'o155;  9'h054: l = 7'o156;  9'h041: l = 7'o157;
      9'h05D: l = 7'o160;  9'h05B: l = 7'o161;  9'h052: l = 7'o162;  9'h16C: l = 7'o163;
      9'h059: l = 7'o164;  9'h175: l = 7'o165;  9'h04A: l = 7'o166;  9'h16B: l = 7'o167;
      9'h016: l = 7'o170;  9'h00E: l = 7'o171;  9'h014: l = 7'o172;  9'h01E: l = 7'o173;
      9'h029: l = 7'o174;  9'h011: l = 7'o175;  9'h015: l = 7'o176;  9'h076: l = 7'o177;
      default: l = '0;
    endcase
    return l;
  endfunction

  always_comb begin
    fall    = clk_filt_q && (clk_hist_q == '0);
    rx_data = data_sync_q[1];
    ext     = (st_q == StExt) || (st_q == StExtBrk);
    lk      = lookup({ext, code_q});
  end

  // Synchroniser, clock glitch filter and frame receiver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_hist_q   <= '1;
      clk_filt_q   <= 1'b1;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      tmo_q        <= '0;
      code_valid_q <= 1'b0;
      code_q       <= 8'h00;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], bus.ps2_clk};
      data_sync_q  <= {data_sync_q[0], bus.ps2_data};
      clk_hist_q   <= {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      code_valid_q <= 1'b0;
      if (&clk_hist_q) begin
        clk_filt_q <= 1'b1;
      end else if (clk_hist_q == '0) begin
        clk_filt_q <= 1'b0;
      end
      if (fall) begin
        tmo_q <= '0;
        case (bit_cnt_q)
          4'd0: if (!rx_data) bit_cnt_q <= 4'd1;
          4'd10: begin
            bit_cnt_q <= '0;
            if (rx_data && (^sr_q)) begin
              code_valid_q <= 1'b1;
              code_q       <= sr_q[7:0];
            end
          end
          default: begin
            sr_q      <= {rx_data, sr_q[8:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        endcase
      end else if (bit_cnt_q != '0) begin
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt_q <= '0;
          tmo_q     <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  // Set-2 sequence decoder and key matrix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= StIdle;
      skip_q     <= '0;
      km_q       <= {8{8'hFF}};
      resetkey_q <= 1'b0;
    end else if (code_valid_q) begin
      case (st_q)
        StIdle: begin
          case (code_q)
            8'hE0: st_q <= StExt;
            8'hF0: st_q <= StBrk;
            8'hE1: begin
              st_q   <= StPause;
              skip_q <= 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
            8'h00, 8'hFF: begin
              km_q       <= {8{8'hFF}};
              resetkey_q <= 1'b0;
            end
            8'h78: resetkey_q <= 1'b1;
            default: if (lk[6]) km_q[lk[5:3]][lk[2:0]] <= 1'b0;
          endcase
        end
        StExt: begin
          if (code_q == 8'hF0) begin
            st_q <= StExtBrk;
          end else begin
            st_q <= StIdle;
            // E0 12 / E0 7C are the keyboard's synthetic shift codes.
            if (code_q != 8'h12 && code_q != 8'h7C && lk[6]) km_q[lk[5:3]][lk[2:0]] <= 1'b0;
          end
        end
        StBrk: begin
          st_q <= StIdle;
          if (code_q == 8'h78) resetkey_q <= 1'b0;
          else if (lk[6]) km_q[lk[5:3]][lk[2:0]] <= 1'b1;
        end
        StExtBrk: begin
          st_q <= StIdle;
          if (lk[6]) km_q[lk[5:3]][lk[2:0]] <= 1'b1;
        end
        StPause: begin
          skip_q <= skip_q - 3'd1;
          if (skip_q <= 3'd1) st_q <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign bus.km         = km_q;
  assign bus.resetkey   = resetkey_q;
  assign bus.code_valid = code_valid_q;
  assign bus.code       = code_q;
endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: byte-sequence table plus latency, timeout and reset cases.
module tb_ps2_key_matrix;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_matrix_if bus ();

  ps2_key_matrix dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] b;
    bit         bad;
    int         row;
    logic [7:0] rv;
    int         n;
    logic       rk;
    bit         cv;
  } vec_t;

  vec_t       vq[$];
  int         checks = 0;
  int         failures = 0;
  int         cv_cnt = 0;
  logic [7:0] last_code = 8'h00;

  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) begin
      cv_cnt++;
      last_code = bus.code;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int n_pressed(input logic [7:0][7:0] k);
    int c = 0;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++)
        if (k[r][j] == 1'b0) c++;
    return c;
  endfunction

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (4) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = (~^b) ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bits(mk_frame(b, bad), 11);
    repeat (8) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vq.push_back('{8'h1C, 0, 1, 8'hFB, 1, 1'b0, 1});
    vq.push_back('{8'hF0, 0, 1, 8'hFB, 1, 1'b0, 1});
    vq.push_back('{8'h1C, 0, 1, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'hE0, 0, 0, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'h74, 0, 0, 8'hFB, 1, 1'b0, 1});
    vq.push_back('{8'hE0, 0, 0, 8'hFB, 1, 1'b0, 1});
    vq.push_back('{8'hF0, 0, 0, 8'hFB, 1, 1'b0, 1});
    vq.push_back('{8'h74, 0, 0, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'h74, 0, 0, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'h1C, 1, 1, 8'hFF, 0, 1'b0, 0});
    vq.push_back('{8'h5A, 0, 0, 8'hFD, 1, 1'b0, 1});
    vq.push_back('{8'hF0, 0, 0, 8'hFD, 1, 1'b0, 1});
    vq.push_back('{8'h5A, 0, 0, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'h12, 0, 1, 8'h7F, 1, 1'b0, 1});
    vq.push_back('{8'h1C, 0, 1, 8'h7B, 2, 1'b0, 1});
    vq.push_back('{8'hFF, 0, 1, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'h78, 0, 1, 8'hFF, 0, 1'b1, 1});
    vq.push_back('{8'hF0, 0, 1, 8'hFF, 0, 1'b1, 1});
    vq.push_back('{8'h78, 0, 1, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'hE0, 0, 1, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'h12, 0, 1, 8'hFF, 0, 1'b0, 1});
    vq.push_back('{8'h29, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'hE1, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'h14, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'h77, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'hE1, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'hF0, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'h14, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'hF0, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'h77, 0, 7, 8'hEF, 1, 1'b0, 1});
    vq.push_back('{8'h59, 0, 6, 8'hEF, 2, 1'b0, 1});
    vq.push_back('{8'hAA, 0, 6, 8'hEF, 2, 1'b0, 1});
    vq.push_back('{8'h66, 0, 0, 8'hFE, 3, 1'b0, 1});
    vq.push_back('{8'h00, 0, 0, 8'hFF, 0, 1'b0, 1});

    rst          = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_km", 64'(bus.km), {64{1'b1}});
    check("rst_resetkey", 64'(bus.resetkey), 64'd0);
    check("rst_code_valid", 64'(bus.code_valid), 64'd0);
    check("rst_code", 64'(bus.code), 64'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Strobe then matrix update one cycle later.
    fork
      send_byte(8'h1C, 1'b0);
      begin
        int k = 0;
        @(negedge clk);
        while (bus.code_valid !== 1'b1 && k < 400) begin
          @(negedge clk);
          k++;
        end
        check("lat_strobe_seen", 64'(k < 400), 64'd1);
        check("lat_code", 64'(bus.code), 64'h1C);
        check("lat_km_before", 64'(bus.km[1]), 64'hFF);
        @(negedge clk);
        check("lat_strobe_width", 64'(bus.code_valid), 64'd0);
        check("lat_km_after", 64'(bus.km[1]), 64'hFB);
        check("lat_npressed", 64'(n_pressed(bus.km)), 64'd1);
      end
    join

    do_reset();
    foreach (vq[i]) begin
      int c0;
      c0 = cv_cnt;
      send_byte(vq[i].b, vq[i].bad);
      check($sformatf("v%0d_row%0d", i, vq[i].row), 64'(bus.km[vq[i].row]), 64'(vq[i].rv));
      check($sformatf("v%0d_npressed", i), 64'(n_pressed(bus.km)), 64'(vq[i].n));
      check($sformatf("v%0d_resetkey", i), 64'(bus.resetkey), 64'(vq[i].rk));
      check($sformatf("v%0d_strobes", i), 64'(cv_cnt - c0), 64'(vq[i].cv));
      if (vq[i].cv) check($sformatf("v%0d_code", i), 64'(last_code), 64'(vq[i].b));
    end

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h1C, 1'b0);
    send_byte(8'h78, 1'b0);
    check("pre_rst_resetkey", 64'(bus.resetkey), 64'd1);
    send_bits(mk_frame(8'h5A, 1'b0), 4);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_km", 64'(bus.km), {64{1'b1}});
    check("midrst_resetkey", 64'(bus.resetkey), 64'd0);
    check("midrst_code", 64'(bus.code), 64'h00);
    check("midrst_code_valid", 64'(bus.code_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h5A, 1'b0);
    check("resync_row0", 64'(bus.km[0]), 64'hFD);
    check("resync_npressed", 64'(n_pressed(bus.km)), 64'd1);
    check("resync_code", 64'(last_code), 64'h5A);

    // Partial frame abandoned by the idle timeout.
    do_reset();
    begin
      int c0;
      c0 = cv_cnt;
      send_bits(mk_frame(8'h29, 1'b0), 5);
      repeat (30000) @(posedge clk);
      send_byte(8'h29, 1'b0);
      check("tmo_row7", 64'(bus.km[7]), 64'hEF);
      check("tmo_npressed", 64'(n_pressed(bus.km)), 64'd1);
      check("tmo_strobes", 64'(cv_cnt - c0), 64'd1);
      check("tmo_code", 64'(last_code), 64'h29);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
